// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: state encodings and PC step constants.
package pc_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_BOOT    = 3'd0;
    localparam state_t ST_RUN     = 3'd1;
    localparam state_t ST_HALT    = 3'd2;
    localparam state_t ST_FAULT   = 3'd3;
    localparam state_t ST_TIMEOUT = 3'd4;

    localparam int PC_INC   = 4;
    localparam int BR_SHIFT = 2;

endpackage

// File: rtl/pc_sequencer_pc_next_calc.sv
// Next-PC selection: sequential step or taken branch, plus word-alignment check of the target.
module pc_next_calc
    import pc_seq_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] imm,
    input  logic            take,
    output logic [PC_W-1:0] next_pc,
    output logic            misaligned
);

    // Arithmetic is modulo 2^PC_W; a negative imm yields a backward branch.
    always_comb begin
        next_pc = pc + PC_W'(PC_INC);
        if (take) begin
            next_pc = pc + (imm << BR_SHIFT);
        end
        misaligned = (next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: boots from startpc, steps once per retired instruction, stops on halt/fault/watchdog.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               PC_W       = 64,
    parameter int               CNT_W      = 16,
    parameter logic [CNT_W-1:0] WDOG_LIMIT = {CNT_W{1'b1}}
) (
    input  logic             CLK,
    input  logic             resetl,
    input  logic [PC_W-1:0]  startpc,
    input  logic             uncondbranch,
    input  logic             branch,
    input  logic             zero,
    input  logic [PC_W-1:0]  signextimm,
    input  logic             halt,
    output logic [PC_W-1:0]  currentpc,
    output logic             running,
    output logic             halted,
    output logic             fault,
    output logic             timeout,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q;
    logic [PC_W-1:0]  pc_q;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] wdog_q;
    logic [PC_W-1:0]  next_pc;
    logic             misaligned;
    logic             active;
    logic             wdog_hit;
    logic [CNT_W-1:0] retired_inc;

    // In BOOT the fetch address comes straight from startpc so it is visible during reset.
    assign currentpc = (state_q == ST_BOOT) ? startpc : pc_q;
    assign active    = (state_q == ST_BOOT) || (state_q == ST_RUN);
    assign wdog_hit  = (WDOG_LIMIT != '0) && (wdog_q == (WDOG_LIMIT - CNT_W'(1)));
    assign retired_inc = (retired_q == '1) ? retired_q : retired_q + CNT_W'(1);

    pc_next_calc #(
        .PC_W(PC_W)
    ) u_next (
        .pc        (currentpc),
        .imm       (signextimm),
        .take      (uncondbranch | (branch & zero)),
        .next_pc   (next_pc),
        .misaligned(misaligned)
    );

    // Terminal states hold everything until the next reset.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q   <= ST_BOOT;
            pc_q      <= '0;
            retired_q <= '0;
            wdog_q    <= '0;
        end else if (active) begin
            wdog_q <= wdog_q + CNT_W'(1);
            if (halt) begin
                state_q   <= ST_HALT;
                pc_q      <= currentpc;
                retired_q <= retired_inc;
            end else if (misaligned) begin
                state_q <= ST_FAULT;
                pc_q    <= currentpc;
            end else begin
                state_q   <= wdog_hit ? ST_TIMEOUT : ST_RUN;
                pc_q      <= next_pc;
                retired_q <= retired_inc;
            end
        end
    end

    assign running = active;
    assign halted  = (state_q == ST_HALT);
    assign fault   = (state_q == ST_FAULT);
    assign timeout = (state_q == ST_TIMEOUT);
    assign retired = retired_q;

endmodule
